// File: rtl/binary_to_bcd.sv
// Sequential double-dabble converter: one binary bit per clock into packed BCD digits.
// Flags overflow when the value does not fit in DIGITS decimal digits (digits wrap mod 10^DIGITS).
module binary_to_bcd #(
    parameter int SIZE   = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [SIZE-1:0]       binary,
    input  logic                  start,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow
);

    localparam int CW = $clog2(SIZE + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t              state;
    logic [SIZE-1:0]     bin_sr;
    logic [4*DIGITS-1:0] scratch;
    logic [4*DIGITS-1:0] adj;
    logic [4*DIGITS:0]   shifted;
    logic [CW-1:0]       cnt;
    logic                ovf_acc;

    // +3 on every digit >= 5 before the shift, so a doubled digit carries cleanly into the next one.
    always_comb begin
        adj = scratch;
        for (int i = 0; i < DIGITS; i++) begin
            if (scratch[4*i +: 4] >= 4'd5)
                adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
        end
    end

    // Bit shifted out of the top digit means the value has reached 10^DIGITS.
    assign shifted = {adj, bin_sr[SIZE-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            bin_sr   <= '0;
            scratch  <= '0;
            cnt      <= '0;
            ovf_acc  <= 1'b0;
            bcd      <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            overflow <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        bin_sr  <= binary;
                        scratch <= '0;
                        cnt     <= CW'(SIZE);
                        ovf_acc <= 1'b0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_sr  <= bin_sr << 1;
                    scratch <= shifted[4*DIGITS-1:0];
                    ovf_acc <= ovf_acc | shifted[4*DIGITS];
                    cnt     <= cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        bcd      <= shifted[4*DIGITS-1:0];
                        overflow <= ovf_acc | shifted[4*DIGITS];
                        done     <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_binary_to_bcd.sv
// Bench for binary_to_bcd: a 4-digit and a 2-digit instance run in lockstep on shared stimulus,
// checked against decimal digits computed with plain division.
module tb_binary_to_bcd;

    localparam int SIZE = 10;

    logic        clk;
    logic        reset;
    logic [9:0]  binary;
    logic        start;
    logic [15:0] bcd;
    logic        busy, done, overflow;
    logic [7:0]  bcd2;
    logic        busy2, done2, overflow2;

    int n_cmp = 0;
    int n_err = 0;
    logic [15:0] prev_bcd;
    logic [7:0]  prev_bcd2;

    binary_to_bcd #(.SIZE(SIZE), .DIGITS(4)) dut (
        .clk(clk), .reset(reset), .binary(binary), .start(start),
        .bcd(bcd), .busy(busy), .done(done), .overflow(overflow)
    );

    binary_to_bcd #(.SIZE(SIZE), .DIGITS(2)) dut2 (
        .clk(clk), .reset(reset), .binary(binary), .start(start),
        .bcd(bcd2), .busy(busy2), .done(done2), .overflow(overflow2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] model_bcd(input int v, input int digits);
        logic [15:0] r;
        int x;
        r = '0;
        x = v;
        for (int i = 0; i < digits; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; start is seen at the next posedge, returns at the following negedge.
    task automatic start_conv(input int v);
        binary = 10'(v);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        chk("busy_after_accept", {31'd0, busy}, 32'd1);
        chk("no_done_after_accept", {31'd0, done}, 32'd0);
        chk("hold_bcd", {16'd0, bcd}, {16'd0, prev_bcd});
        chk("hold_bcd2", {24'd0, bcd2}, {24'd0, prev_bcd2});
    endtask

    // Waits for done (scrambling binary meanwhile) and checks result; leaves us at the done negedge.
    task automatic wait_check(input int v, input bit poke);
        int  lat;
        bit  got;
        got = 1'b0;
        lat = 0;
        for (int n = 1; n <= SIZE + 6; n++) begin
            binary = 10'($urandom);
            start  = poke && (n == 3 || n == 7);
            if (poke && start) binary = 10'd7;
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                got = 1'b1;
                lat = n;
                break;
            end
        end
        chk("done_seen", {31'd0, got}, 32'd1);
        chk("latency", lat, SIZE);
        chk("bcd4", {16'd0, bcd}, {16'd0, model_bcd(v, 4)});
        chk("ovf4", {31'd0, overflow}, {31'd0, (v >= 10000)});
        chk("bcd2", {24'd0, bcd2}, {24'd0, model_bcd(v, 2)});
        chk("ovf2", {31'd0, overflow2}, {31'd0, (v >= 100)});
        chk("busy_clear", {31'd0, busy}, 32'd0);
        prev_bcd  = model_bcd(v, 4);
        prev_bcd2 = model_bcd(v, 2)[7:0];
    endtask

    task automatic run(input int v);
        @(negedge clk);
        start_conv(v);
        wait_check(v, 1'b0);
        @(negedge clk);
        chk("done_single", {31'd0, done}, 32'd0);
    endtask

    task automatic quiet(input string tag, input int cycles);
        int dn;
        dn = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (done) dn++;
        end
        chk(tag, dn, 0);
    endtask

    initial begin
        reset     = 1'b1;
        start     = 1'b0;
        binary    = '0;
        prev_bcd  = '0;
        prev_bcd2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_bcd", {16'd0, bcd}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_done", {31'd0, done}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b0;

        run(0);
        run(1023);
        run(255);

        // start pulses while busy must be ignored
        @(negedge clk);
        start_conv(509);
        wait_check(509, 1'b1);
        chk("poke_bcd", {16'd0, bcd}, 32'h0509);
        quiet("poke_no_extra_done", 14);

        // back-to-back: new start presented in the done cycle
        @(negedge clk);
        start_conv(42);
        wait_check(42, 1'b0);
        start_conv(999);
        wait_check(999, 1'b0);
        chk("b2b_bcd", {16'd0, bcd}, 32'h0999);

        // reset mid-conversion abandons it
        @(negedge clk);
        start_conv(777);
        repeat (4) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_busy", {31'd0, busy}, 32'd0);
        chk("mid_rst_bcd", {16'd0, bcd}, 32'd0);
        chk("mid_rst_done", {31'd0, done}, 32'd0);
        chk("mid_rst_bcd2", {24'd0, bcd2}, 32'd0);
        prev_bcd  = '0;
        prev_bcd2 = '0;
        quiet("mid_rst_no_done", 12);
        run(12);

        // short-digit instance: overflow sets then clears
        run(100);
        run(99);

        // divider chain: 1000/7 quotient then remainder
        run(1000 / 7);
        run(1000 % 7);

        for (int i = 0; i < 25; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run(int'($urandom_range(0, 1023)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
